adxl362_spi_slave_v2: RTL and testbench

Parametrised, single-clock SPI slave register-access engine for the ADXL362 behavioural model. SCLK/MOSI/nCS are oversampled and synchronised into clk_16mhz, which removes the SCLK-domain logic and the byte FIFO used previously. It decodes the ADXL362 write (0x0A), read (0x0B) and FIFO-read (0x0D) commands, and supports multi-byte bursts with address auto-increment. CPOL/CPHA are selectable and unknown commands are handled explicitly.

---
 rtl/adxl362_spi_slave_v2.sv | 200 ++++++++++++++++++++
 tb/tb_adxl362_spi_slave_v2.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_spi_slave_v2.sv
// SPI slave register-access engine for the ADXL362 model: SCLK/MOSI/nCS are oversampled in clk_16mhz,
// commands 0x0A write, 0x0B read, 0x0D FIFO read, with burst auto-increment and selectable CPOL/CPHA.
module adxl362_spi_slave_v2 #(
   parameter int ADDR_WIDTH  = 6,
   parameter int ADDR_MAX    = 63,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_16mhz,
   input  logic                  reset,
   input  logic                  SCLK,
   input  logic                  MOSI,
   input  logic                  nCS,
   output logic                  MISO,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [7:0]            data_write,
   output logic                  write,
   output logic                  read,
   output logic                  fifo_read,
   input  logic [7:0]            data_read,
   output logic                  cmd_error,
   output logic                  busy
);

   typedef enum logic [3:0] {
      IDLE, CMD, ADDR_W, WDATA, ADDR_R, RLOAD, FIFO_LOAD, RDATA, DISCARD
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, mosi_sync_q, ncs_sync_q, vld_q;
   logic                    sclk_prev_q, ncs_prev_q, armed_q, armed_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [6:0]              rx_q, rx_d;
   logic [7:0]              tx_q, tx_d, rx_byte;
   logic                    miso_q, miso_d;
   logic [ADDR_WIDTH-1:0]   address_q, address_d, addr_inc;
   logic [7:0]              data_write_q, data_write_d;
   logic                    write_q, write_d, read_q, read_d, fifo_read_q, fifo_read_d;
   logic                    cmd_error_q, cmd_error_d, fifo_mode_q, fifo_mode_d;
   logic                    sclk_s, mosi_s, ncs_s, sclk_rise, sclk_fall, ncs_rise, ncs_fall;
   logic                    sample_edge, shift_edge, byte_done;

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign ncs_rise    = ncs_s & ~ncs_prev_q;
   assign ncs_fall    = ~ncs_s & ncs_prev_q;
   assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
   assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
   assign rx_byte     = {rx_q, mosi_s};
   assign addr_inc    = (address_q == ADDR_WIDTH'(ADDR_MAX)) ? '0 : address_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      miso_d       = 1'b0;
      address_d    = address_q;
      data_write_d = data_write_q;
      write_d      = 1'b0;
      read_d       = 1'b0;
      fifo_read_d  = 1'b0;
      cmd_error_d  = cmd_error_q;
      fifo_mode_d  = fifo_mode_q;
      byte_done    = 1'b0;
      // a falling nCS only counts once a real (non-preloaded) high level has been seen after reset
      armed_d      = armed_q | (vld_q[SYNC_STAGES-1] & ncs_s);
      if (write_q) address_d = addr_inc;
      if (ncs_rise) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
      end else if (ncs_fall && armed_q) begin
         state_d     = CMD;
         bit_cnt_d   = 3'd0;
         cmd_error_d = 1'b0;
      end else if (state_q != IDLE) begin
         if (sample_edge) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
         end
         if (state_q == RDATA) begin
            miso_d = miso_q;
            // with CPHA=0 the MSB is already on MISO, so the trailing edge after the last sample is skipped
            if (shift_edge && (CPHA || bit_cnt_q != 3'd0)) begin
               miso_d = tx_q[7];
               tx_d   = {tx_q[6:0], 1'b0};
            end
         end
         case (state_q)
            CMD: if (byte_done) begin
               case (rx_byte)
                  8'h0A:   state_d = ADDR_W;
                  8'h0B:   state_d = ADDR_R;
                  8'h0D:   state_d = FIFO_LOAD;
                  default: begin
                     state_d     = DISCARD;
                     cmd_error_d = 1'b1;
                  end
               endcase
            end
            ADDR_W: if (byte_done) begin
               address_d = rx_byte[ADDR_WIDTH-1:0];
               state_d   = WDATA;
            end
            WDATA: if (byte_done) begin
               data_write_d = rx_byte;
               write_d      = 1'b1;
            end
            ADDR_R: if (byte_done) begin
               address_d   = rx_byte[ADDR_WIDTH-1:0];
               read_d      = 1'b1;
               fifo_mode_d = 1'b0;
               state_d     = RLOAD;
            end
            FIFO_LOAD: begin
               fifo_read_d = 1'b1;
               fifo_mode_d = 1'b1;
               state_d     = RLOAD;
            end
            RLOAD: if (!read_q && !fifo_read_q) begin
               tx_d    = data_read;
               state_d = RDATA;
               if (!CPHA) begin
                  miso_d = data_read[7];
                  tx_d   = {data_read[6:0], 1'b0};
               end
            end
            RDATA: if (byte_done) begin
               if (fifo_mode_q) begin
                  fifo_read_d = 1'b1;
               end else begin
                  address_d = addr_inc;
                  read_d    = 1'b1;
               end
               state_d = RLOAD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         sclk_sync_q  <= {SYNC_STAGES{CPOL}};
         mosi_sync_q  <= '0;
         ncs_sync_q   <= '1;
         vld_q        <= '0;
         sclk_prev_q  <= CPOL;
         ncs_prev_q   <= 1'b1;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         rx_q         <= '0;
         tx_q         <= '0;
         miso_q       <= 1'b0;
         address_q    <= '0;
         data_write_q <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         fifo_read_q  <= 1'b0;
         cmd_error_q  <= 1'b0;
         fifo_mode_q  <= 1'b0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         ncs_sync_q   <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
         vld_q        <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q  <= sclk_s;
         ncs_prev_q   <= ncs_s;
         armed_q      <= armed_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         miso_q       <= miso_d;
         address_q    <= address_d;
         data_write_q <= data_write_d;
         write_q      <= write_d;
         read_q       <= read_d;
         fifo_read_q  <= fifo_read_d;
         cmd_error_q  <= cmd_error_d;
         fifo_mode_q  <= fifo_mode_d;
      end
   end

   assign MISO       = miso_q;
   assign address    = address_q;
   assign data_write = data_write_q;
   assign write      = write_q;
   assign read       = read_q;
   assign fifo_read  = fifo_read_q;
   assign cmd_error  = cmd_error_q;
   assign busy       = ~ncs_s;

endmodule

// File: tb/tb_adxl362_spi_slave_v2.sv
// Directed bench for adxl362_spi_slave_v2: one mode-0 and one mode-3 instance share nCS/MOSI,
// each with its own SCLK, register/FIFO model and strobe log.
`timescale 1ns/1ps
module tb_adxl362_spi_slave_v2;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst, mosi, ncs;
   logic       sclk [2];
   logic       miso [2];
   logic [5:0] addr [2];
   logic [7:0] dw [2];
   logic [7:0] dr [2];
   logic       wr [2], rd [2], fr [2], cerr [2], bsy [2];
   int         wn [2], rn [2], fn [2], fcnt [2];
   logic [13:0] wlog [2][64];
   logic [5:0]  rlog [2][64];
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   adxl362_spi_slave_v2 #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk_16mhz(clk), .reset(rst), .SCLK(sclk[0]), .MOSI(mosi), .nCS(ncs), .MISO(miso[0]),
      .address(addr[0]), .data_write(dw[0]), .write(wr[0]), .read(rd[0]), .fifo_read(fr[0]),
      .data_read(dr[0]), .cmd_error(cerr[0]), .busy(bsy[0]));

   adxl362_spi_slave_v2 #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
      .clk_16mhz(clk), .reset(rst), .SCLK(sclk[1]), .MOSI(mosi), .nCS(ncs), .MISO(miso[1]),
      .address(addr[1]), .data_write(dw[1]), .write(wr[1]), .read(rd[1]), .fifo_read(fr[1]),
      .data_read(dr[1]), .cmd_error(cerr[1]), .busy(bsy[1]));

   // register file returns addr+0x80; FIFO returns 0xA1, 0xA2, ...
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            fcnt[d] <= 0;
            dr[d]   <= 8'h00;
         end else if (rd[d]) begin
            dr[d] <= 8'h80 + {2'b00, addr[d]};
         end else if (fr[d]) begin
            dr[d]   <= 8'hA1 + 8'(fcnt[d]);
            fcnt[d] <= fcnt[d] + 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (wr[d]) begin
            if (wn[d] < 64) wlog[d][wn[d]] <= {addr[d], dw[d]};
            wn[d] <= wn[d] + 1;
         end
         if (rd[d]) begin
            if (rn[d] < 64) rlog[d][rn[d]] <= addr[d];
            rn[d] <= rn[d] + 1;
         end
         if (fr[d]) fn[d] <= fn[d] + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input int m, input logic [7:0] tx, input int nb, output logic [7:0] rxb);
      rxb = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         if (m == 1) sclk[1] = 1'b0;
         mosi = tx[i];
         cyc(HALF);
         sclk[m] = 1'b1;
         rxb = {rxb[6:0], miso[m]};
         cyc(HALF);
         if (m == 0) sclk[0] = 1'b0;
      end
   endtask

   task automatic cs_low();
      ncs = 1'b0;
      cyc(8);
   endtask

   task automatic cs_high();
      cyc(8);
      ncs = 1'b1;
      cyc(10);
   endtask

   task automatic test_reset();
      rst = 1'b1; ncs = 1'b1; mosi = 1'b0; sclk[0] = 1'b0; sclk[1] = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(4);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (addr[d] !== 6'h00 || dw[d] !== 8'h00) begin
            bad++; $display("FAIL reset_bus dut%0d addr=%0h dw=%0h want 0/0", d, addr[d], dw[d]);
         end
         total++;
         if ({wr[d], rd[d], fr[d], miso[d], cerr[d], bsy[d]} !== 6'b0) begin
            bad++; $display("FAIL reset_flags dut%0d got=%b want=000000", d,
                            {wr[d], rd[d], fr[d], miso[d], cerr[d], bsy[d]});
         end
      end
   endtask

   task automatic test_write(input int m);
      logic [7:0]  bs [5] = '{8'h0A, 8'h20, 8'h11, 8'h22, 8'h33};
      logic [13:0] ex [3] = '{{6'h20, 8'h11}, {6'h21, 8'h22}, {6'h22, 8'h33}};
      logic [7:0]  rxb;
      int w0 = wn[m], r0 = rn[m];
      cs_low();
      for (int k = 0; k < 5; k++) spi_bits(m, bs[k], 8, rxb);
      cs_high();
      total++;
      if (wn[m] - w0 != 3) begin bad++; $display("FAIL write_count m%0d got=%0d want=3", m, wn[m] - w0); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (wlog[m][w0 + k] !== ex[k]) begin
            bad++; $display("FAIL write_%0d m%0d got=%h want=%h", k, m, wlog[m][w0 + k], ex[k]);
         end
      end
      total++;
      if (rn[m] - r0 != 0) begin bad++; $display("FAIL write_no_read m%0d got=%0d want=0", m, rn[m] - r0); end
      total++;
      if (cerr[m] !== 1'b0) begin bad++; $display("FAIL write_cmd_error m%0d got=%b want=0", m, cerr[m]); end
      total++;
      if (addr[m] !== 6'h23) begin bad++; $display("FAIL write_addr_after m%0d got=%h want=23", m, addr[m]); end
   endtask

   task automatic test_read_wrap(input int m);
      logic [7:0] bs [4] = '{8'h0B, 8'h3F, 8'h00, 8'h00};
      logic [7:0] ex [4] = '{8'h00, 8'h00, 8'hBF, 8'h80};
      logic [5:0] ea [3] = '{6'h3F, 6'h00, 6'h01};
      logic [7:0] rxb;
      int r0 = rn[m], f0 = fn[m];
      cs_low();
      for (int k = 0; k < 4; k++) begin
         spi_bits(m, bs[k], 8, rxb);
         total++;
         if (rxb !== ex[k]) begin bad++; $display("FAIL read_miso_%0d m%0d got=%h want=%h", k, m, rxb, ex[k]); end
      end
      cs_high();
      total++;
      if (rn[m] - r0 != 3) begin bad++; $display("FAIL read_count m%0d got=%0d want=3", m, rn[m] - r0); end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (rlog[m][r0 + k] !== ea[k]) begin
            bad++; $display("FAIL read_addr_%0d m%0d got=%h want=%h", k, m, rlog[m][r0 + k], ea[k]);
         end
      end
      total++;
      if (fn[m] - f0 != 0) begin bad++; $display("FAIL read_no_fifo m%0d got=%0d want=0", m, fn[m] - f0); end
   endtask

   task automatic test_fifo();
      logic [7:0] ex [4] = '{8'h00, 8'hA1, 8'hA2, 8'hA3};
      logic [7:0] rxb;
      int r0 = rn[0], f0 = fn[0];
      cs_low();
      spi_bits(0, 8'h0D, 8, rxb);
      total++;
      if (rxb !== ex[0]) begin bad++; $display("FAIL fifo_miso_cmd got=%h want=00", rxb); end
      for (int k = 1; k < 4; k++) begin
         spi_bits(0, 8'h00, 8, rxb);
         total++;
         if (rxb !== ex[k]) begin bad++; $display("FAIL fifo_miso_%0d got=%h want=%h", k, rxb, ex[k]); end
      end
      cs_high();
      total++;
      if (fn[0] - f0 < 3) begin bad++; $display("FAIL fifo_count got=%0d want>=3", fn[0] - f0); end
      total++;
      if (rn[0] - r0 != 0) begin bad++; $display("FAIL fifo_no_read got=%0d want=0", rn[0] - r0); end
      total++;
      if (addr[0] !== 6'h01) begin bad++; $display("FAIL fifo_addr_held got=%h want=01", addr[0]); end
   endtask

   task automatic test_unknown();
      logic [7:0] bs [3] = '{8'h55, 8'h01, 8'h02};
      logic [7:0] rxb;
      int w0 = wn[0], r0 = rn[0], f0 = fn[0];
      cs_low();
      for (int k = 0; k < 3; k++) begin
         spi_bits(0, bs[k], 8, rxb);
         total++;
         if (rxb !== 8'h00) begin bad++; $display("FAIL unk_miso_%0d got=%h want=00", k, rxb); end
      end
      cs_high();
      total++;
      if (cerr[0] !== 1'b1) begin bad++; $display("FAIL unk_cmd_error got=%b want=1", cerr[0]); end
      total++;
      if ((wn[0] - w0) + (rn[0] - r0) + (fn[0] - f0) != 0) begin
         bad++; $display("FAIL unk_strobes got=%0d/%0d/%0d want=0/0/0", wn[0] - w0, rn[0] - r0, fn[0] - f0);
      end
      ncs = 1'b0;
      cyc(8);
      total++;
      if (cerr[0] !== 1'b0) begin bad++; $display("FAIL unk_clear got=%b want=0", cerr[0]); end
      ncs = 1'b1;
      cyc(10);
   endtask

   task automatic test_abort();
      logic [7:0] rxb;
      int w0 = wn[0];
      cs_low();
      spi_bits(0, 8'h0A, 8, rxb);
      spi_bits(0, 8'h05, 8, rxb);
      spi_bits(0, 8'hFF, 4, rxb);
      cs_high();
      total++;
      if (wn[0] - w0 != 0) begin bad++; $display("FAIL abort_no_write got=%0d want=0", wn[0] - w0); end
      total++;
      if ({addr[0], bsy[0], miso[0]} !== {6'h05, 2'b00}) begin
         bad++; $display("FAIL abort_idle addr=%h busy=%b miso=%b want 05/0/0", addr[0], bsy[0], miso[0]);
      end
      cs_low();
      spi_bits(0, 8'h0A, 8, rxb);
      spi_bits(0, 8'h07, 8, rxb);
      spi_bits(0, 8'h5A, 8, rxb);
      cs_high();
      total++;
      if (wn[0] - w0 != 1 || wlog[0][w0] !== {6'h07, 8'h5A}) begin
         bad++; $display("FAIL abort_recover count=%0d got=%h want=1/075a", wn[0] - w0, wlog[0][w0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rxb;
      int r0, w0;
      cs_low();
      spi_bits(0, 8'h0B, 8, rxb);
      spi_bits(0, 8'h10, 8, rxb);
      spi_bits(0, 8'h00, 8, rxb);
      spi_bits(0, 8'h00, 2, rxb);
      rst = 1'b1;
      cyc(1);
      total++;
      if ({addr[0], dw[0], wr[0], rd[0], fr[0], miso[0], cerr[0], bsy[0]} !== 20'h0) begin
         bad++; $display("FAIL rstmid_outputs got addr=%h dw=%h flags=%b want all 0", addr[0], dw[0],
                         {wr[0], rd[0], fr[0], miso[0], cerr[0], bsy[0]});
      end
      rst = 1'b0;
      cyc(6);
      r0 = rn[0];
      spi_bits(0, 8'h0B, 8, rxb);
      spi_bits(0, 8'h10, 8, rxb);
      cs_high();
      total++;
      if (rn[0] - r0 != 0) begin bad++; $display("FAIL rstmid_no_resume got=%0d want=0", rn[0] - r0); end
      w0 = wn[0];
      cs_low();
      spi_bits(0, 8'h0A, 8, rxb);
      spi_bits(0, 8'h3E, 8, rxb);
      spi_bits(0, 8'h77, 8, rxb);
      cs_high();
      total++;
      if (wn[0] - w0 != 1 || wlog[0][w0] !== {6'h3E, 8'h77}) begin
         bad++; $display("FAIL rstmid_recover count=%0d got=%h want=1/3e77", wn[0] - w0, wlog[0][w0]);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         wn[d] = 0; rn[d] = 0; fn[d] = 0;
      end
      test_reset();
      test_write(0);
      test_read_wrap(0);
      test_fifo();
      test_write(1);
      test_read_wrap(1);
      test_unknown();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
